encoder_irq_sequencer: RTL and testbench
========================================

# encoder_irq_sequencer

Autonomous Avalon-MM master that services the 4-bit encoder edge-capture PIO in hardware instead of in the NIOS ISR. It programs the PIO interrupt mask, answers its irq by reading and clearing edge capture, samples the encoder pins, and keeps two signed quadrature position counters. A poll timer covers falling edges, because the PIO captures rising edges only.

## Interface
- POS_W, 32, width of each position counter
- IRQ_MASK_INIT, 4'hF, value written to PIO irq_mask (address 2) after reset
- POLL_PERIOD, 1000, clk cycles between idle polls of the pin state; 0 disables polling

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- m_address  out  2  PIO register address
- m_chipselect  out  1  PIO chipselect
- m_write_n  out  1  PIO write strobe, active-low
- m_writedata  out  32  PIO write data
- m_readdata  in  32  PIO readdata; registered in the PIO, so 1-cycle latency from address
- irq_in  in  1  PIO irq
- en  in  1  service enable
- clr  in  1  synchronous clear of positions and error flags
- pos0, pos1  out  POS_W  signed position, encoder 0 (pins 1:0) and encoder 1 (pins 3:2)
- err0, err1  out  1  sticky illegal-transition flags
- last_cap  out  4  edge-capture value from the most recent irq service
- upd  out  1  one-cycle pulse in the UPDATE state
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Pin map: A0=bit0, B0=bit1, A1=bit2, B1=bit3. Per-encoder state s={B,A}.
- Forward sequence is 00→01→11→10→00, giving +1 per step; the reverse steps give −1; no change gives 0.
- A double step (00↔11 or 01↔10) gives 0 and sets the sticky errN flag.
- Counters wrap modulo 2^POS_W.
- FSM states:
  - BOOT: reset state. Bus idle. Next state is INIT.
  - INIT: write IRQ_MASK_INIT to address 2. Next state is PRIME_ISS.
  - PRIME_ISS / PRIME_WT: read address 0. Store the pins as prev. Counters do not change. Next state is IDLE.
  - IDLE: if en and irq_in, go to CAP_ISS. Else, if en and the poll timer has expired, go to DAT_ISS. Else stay.
  - CAP_ISS / CAP_WT: read address 3. Latch last_cap = m_readdata[3:0] in CAP_WT.
  - CAP_CLR: write last_cap to address 3. This clears the PIO capture and drops irq.
  - DAT_ISS / DAT_WT: read address 0. Latch cur = m_readdata[3:0] in DAT_WT.
  - UPDATE: apply the decode of (prev, cur) to both counters, set prev=cur, pulse upd, reload the poll timer. Next state is IDLE.
- Bus encoding:
  - Idle: chipselect=0, write_n=1, address=0, writedata=0.
  - Read states (*_ISS, *_WT): chipselect=1, write_n=1, and the address is held across both ISS and WT.
  - Write states: chipselect=1, write_n=0 for exactly one cycle.
  - All m_* outputs are decoded from state.
- The poll timer counts down only in IDLE. It reaches expiry after POLL_PERIOD idle cycles and reloads on UPDATE.
- Simultaneous irq and poll expiry: the irq path is taken, and it also refreshes the position.
- en low: the current sequence runs to IDLE, then the FSM holds in IDLE. The poll timer is frozen.
- clr: zeroes pos0/1 and err0/1. prev is untouched. If clr and UPDATE fall in the same cycle, clr wins and that delta is discarded.
- An edge arriving between CAP_WT and CAP_CLR is dropped from capture. DAT_ISS follows CAP_CLR, so the edge is still reflected in cur.

## Timing
- Reset values: pos0/1=0, err0/1=0, last_cap=0, upd=0, busy=1 (BOOT), bus idle, prev=0, poll timer=POLL_PERIOD.
- After reset release:
  - Cycle 0 is BOOT, cycle 1 is INIT, cycles 2–3 are PRIME, and IDLE is reached at cycle 4.
- Irq service is 7 cycles:
  - irq is seen in IDLE at cycle T.
  - CAP_ISS at T+1, CAP_WT at T+2, CAP_CLR at T+3, DAT_ISS at T+4, DAT_WT at T+5, UPDATE at T+6.
  - pos is visible at T+7, and irq_in is low by T+5 if no new edge occurs.
- Poll service: DAT_ISS, DAT_WT, UPDATE. pos is visible 4 cycles after expiry.
- Reset asserted mid-sequence aborts immediately to BOOT, with all registers at their reset values.

## Test plan
- Reset, then idle bus: write 0xF to address 2 at cycle 1, read address 0 in cycles 2–3, IDLE at cycle 4, pos0=pos1=0.
- Encoder 0 forward 00→01→11→10→00, with irq on each rising edge plus polling → pos0=+4, err0=0. The reverse sequence then returns pos0=0.
- Encoder 1 jump 00→11 between samples → pos1 unchanged, err1=1 and stays 1 until a clr pulse, then 0.
- pos0=0x7FFFFFFF plus one forward step → 0x80000000. pos1=0 plus one reverse step → 0xFFFFFFFF.
- irq and poll expiry in the same cycle → a single 7-cycle irq sequence, one upd pulse, poll timer reloaded.
- en=0 mid-sequence → sequence completes, FSM stays in IDLE with a pending irq and busy=0. en=1 → service starts the next cycle.

Source files
------------

// File: rtl/encoder_irq_sequencer.sv
// Hardware service engine for the 4-bit encoder edge-capture PIO.
// Programs the PIO irq mask after reset, services its irq by reading and
// clearing edge capture, samples the pins on irq or on an idle poll timer,
// and keeps two signed quadrature position counters with sticky error flags.
module encoder_irq_sequencer #(
  parameter int         POS_W         = 32,
  parameter logic [3:0] IRQ_MASK_INIT = 4'hF,
  parameter int         POLL_PERIOD   = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  input  logic             irq_in,
  input  logic             en,
  input  logic             clr,
  output logic [POS_W-1:0] pos0,
  output logic [POS_W-1:0] pos1,
  output logic             err0,
  output logic             err1,
  output logic [3:0]       last_cap,
  output logic             upd,
  output logic             busy
);

  localparam int PT_W = (POLL_PERIOD < 2) ? 1 : $clog2(POLL_PERIOD + 1);
  localparam logic [PT_W-1:0] PT_INIT = PT_W'(POLL_PERIOD);

  typedef enum logic [3:0] {
    S_BOOT,
    S_INIT,
    S_PRIME_ISS,
    S_PRIME_WT,
    S_IDLE,
    S_CAP_ISS,
    S_CAP_WT,
    S_CAP_CLR,
    S_DAT_ISS,
    S_DAT_WT,
    S_UPDATE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PT_W-1:0]   r_poll;
  logic              w_poll_exp;
  logic [3:0]        r_prev;
  logic [3:0]        r_cur;
  logic [3:0]        r_last_cap;
  logic [POS_W-1:0]  r_pos0;
  logic [POS_W-1:0]  r_pos1;
  logic              r_err0;
  logic              r_err1;
  logic [1:0]        w_d0;
  logic [1:0]        w_d1;
  logic              w_unused_rd;

  // Position of a {B,A} pin pair along the forward cycle 00,01,11,10.
  function automatic logic [1:0] gidx(input logic [1:0] s);
    case (s)
      2'b00:   gidx = 2'd0;
      2'b01:   gidx = 2'd1;
      2'b11:   gidx = 2'd2;
      default: gidx = 2'd3;
    endcase
  endfunction

  // Step distance mod 4: 1 forward, 3 reverse, 2 illegal double step.
  assign w_d0 = gidx(r_cur[1:0]) - gidx(r_prev[1:0]);
  assign w_d1 = gidx(r_cur[3:2]) - gidx(r_prev[3:2]);

  assign w_poll_exp  = (POLL_PERIOD != 0) && (r_poll == PT_W'(1));
  assign w_unused_rd = ^m_readdata[31:4];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_BOOT;
    else          r_state <= w_next;
  end

  // Next-state decode; irq has priority over poll expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:      w_next = S_INIT;
      S_INIT:      w_next = S_PRIME_ISS;
      S_PRIME_ISS: w_next = S_PRIME_WT;
      S_PRIME_WT:  w_next = S_IDLE;
      S_IDLE: begin
        if (en && irq_in)          w_next = S_CAP_ISS;
        else if (en && w_poll_exp) w_next = S_DAT_ISS;
      end
      S_CAP_ISS:   w_next = S_CAP_WT;
      S_CAP_WT:    w_next = S_CAP_CLR;
      S_CAP_CLR:   w_next = S_DAT_ISS;
      S_DAT_ISS:   w_next = S_DAT_WT;
      S_DAT_WT:    w_next = S_UPDATE;
      S_UPDATE:    w_next = S_IDLE;
      default:     w_next = S_BOOT;
    endcase
  end

  // Bus and status outputs decoded purely from state.
  always_comb begin
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = 2'd0;
    m_writedata  = '0;
    case (r_state)
      S_INIT: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 2'd2;
        m_writedata  = 32'(IRQ_MASK_INIT);
      end
      S_PRIME_ISS, S_PRIME_WT, S_DAT_ISS, S_DAT_WT: begin
        m_chipselect = 1'b1;
        m_address    = 2'd0;
      end
      S_CAP_ISS, S_CAP_WT: begin
        m_chipselect = 1'b1;
        m_address    = 2'd3;
      end
      S_CAP_CLR: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 2'd3;
        m_writedata  = 32'(r_last_cap);
      end
      default: ;
    endcase
    upd  = (r_state == S_UPDATE);
    busy = (r_state != S_IDLE);
  end

  // Poll timer: counts only while enabled and staying in IDLE, reloads on UPDATE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll <= PT_INIT;
    end else if (r_state == S_UPDATE) begin
      r_poll <= PT_INIT;
    end else if ((r_state == S_IDLE) && en && !irq_in && !w_poll_exp &&
                 (r_poll != '0)) begin
      r_poll <= r_poll - PT_W'(1);
    end
  end

  // Readdata captures in the wait states; prev follows cur on UPDATE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_cur      <= '0;
      r_last_cap <= '0;
    end else begin
      case (r_state)
        S_PRIME_WT: r_prev     <= m_readdata[3:0];
        S_CAP_WT:   r_last_cap <= m_readdata[3:0];
        S_DAT_WT:   r_cur      <= m_readdata[3:0];
        S_UPDATE:   r_prev     <= r_cur;
        default: ;
      endcase
    end
  end

  // Position counters and sticky errors; clr overrides a coincident UPDATE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos0 <= '0;
      r_pos1 <= '0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else if (clr) begin
      r_pos0 <= '0;
      r_pos1 <= '0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else if (r_state == S_UPDATE) begin
      if (w_d0 == 2'd1)      r_pos0 <= r_pos0 + POS_W'(1);
      else if (w_d0 == 2'd3) r_pos0 <= r_pos0 - POS_W'(1);
      if (w_d0 == 2'd2)      r_err0 <= 1'b1;
      if (w_d1 == 2'd1)      r_pos1 <= r_pos1 + POS_W'(1);
      else if (w_d1 == 2'd3) r_pos1 <= r_pos1 - POS_W'(1);
      if (w_d1 == 2'd2)      r_err1 <= 1'b1;
    end
  end

  assign pos0     = r_pos0;
  assign pos1     = r_pos1;
  assign err0     = r_err0;
  assign err1     = r_err1;
  assign last_cap = r_last_cap;

endmodule

// File: tb/tb_encoder_irq_sequencer.sv
// Bench for encoder_irq_sequencer: drives encoder pins through a small
// edge-capture PIO model and checks every cycle against a transaction-level
// reference, plus directed literal checks of the key scenarios.
module tb_encoder_irq_sequencer;

  localparam int TB_W = 8;
  localparam int TB_P = 24;
  localparam int GAP  = 36;

  logic            clk;
  logic            reset_n;
  logic [1:0]      m_address;
  logic            m_chipselect;
  logic            m_write_n;
  logic [31:0]     m_writedata;
  logic [31:0]     m_readdata;
  logic            irq_in;
  logic            en;
  logic            clr;
  logic [TB_W-1:0] pos0;
  logic [TB_W-1:0] pos1;
  logic            err0;
  logic            err1;
  logic [3:0]      last_cap;
  logic            upd;
  logic            busy;

  int checks = 0;
  int errors = 0;

  encoder_irq_sequencer #(
    .POS_W(TB_W),
    .IRQ_MASK_INIT(4'hF),
    .POLL_PERIOD(TB_P)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .irq_in(irq_in),
    .en(en), .clr(clr),
    .pos0(pos0), .pos1(pos1), .err0(err0), .err1(err1),
    .last_cap(last_cap), .upd(upd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- PIO model (environment) ----------------
  logic [3:0] pins;
  logic [3:0] pins_d;
  logic [3:0] pio_mask;
  logic [3:0] pio_cap;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_readdata <= '0;
      pins_d     <= '0;
      pio_mask   <= '0;
      pio_cap    <= '0;
    end else begin
      case (m_address)
        2'd0:    m_readdata <= {28'd0, pins};
        2'd2:    m_readdata <= {28'd0, pio_mask};
        2'd3:    m_readdata <= {28'd0, pio_cap};
        default: m_readdata <= '0;
      endcase
      pins_d <= pins;
      if (m_chipselect && !m_write_n && m_address == 2'd2)
        pio_mask <= m_writedata[3:0];
      if (m_chipselect && !m_write_n && m_address == 2'd3)
        pio_cap <= (pio_cap | (pins & ~pins_d)) & ~m_writedata[3:0];
      else
        pio_cap <= pio_cap | (pins & ~pins_d);
    end
  end

  assign irq_in = |(pio_cap & pio_mask);

  // ---------------- reference model ----------------
  localparam int K_NONE = 0, K_PRIME = 1, K_CAP = 2, K_CUR = 3, K_UPD = 4, K_CLRW = 5;

  typedef struct {
    bit        cs;
    bit        wn;
    bit [1:0]  addr;
    bit [31:0] wd;
    int        kind;
  } beat_t;

  beat_t           mq[$];
  logic [TB_W-1:0] m_pos0, m_pos1;
  logic            m_err0, m_err1;
  logic [3:0]      m_last_cap, m_prev, m_cur;
  int              m_idle_cnt;

  function automatic beat_t mk(bit cs, bit wn, bit [1:0] a, bit [31:0] wd, int k);
    beat_t b;
    b.cs = cs; b.wn = wn; b.addr = a; b.wd = wd; b.kind = k;
    return b;
  endfunction

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // +1 / -1 / 0 and error flag for one encoder transition p -> c
  function automatic void step_of(input logic [1:0] p, input logic [1:0] c,
                                  output int d, output bit e);
    e = 0; d = 0;
    if (c == p)           d = 0;
    else if (c == fwd(p)) d = 1;
    else if (p == fwd(c)) d = -1;
    else                  e = 1;
  endfunction

  function automatic void push_dat();
    mq.push_back(mk(1, 1, 2'd0, 0, K_NONE));
    mq.push_back(mk(1, 1, 2'd0, 0, K_CUR));
    mq.push_back(mk(0, 1, 2'd0, 0, K_UPD));
  endfunction

  initial begin : model
    beat_t b;
    bit    have;
    int    d;
    bit    e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mq.delete();
        mq.push_back(mk(0, 1, 2'd0, 0, K_NONE));
        mq.push_back(mk(1, 0, 2'd2, 32'hF, K_NONE));
        mq.push_back(mk(1, 1, 2'd0, 0, K_NONE));
        mq.push_back(mk(1, 1, 2'd0, 0, K_PRIME));
        m_pos0 = '0; m_pos1 = '0; m_err0 = 0; m_err1 = 0;
        m_last_cap = '0; m_prev = '0; m_cur = '0; m_idle_cnt = 0;
      end
      have = (mq.size() > 0);
      b = have ? mq[0] : mk(0, 1, 2'd0, 0, K_NONE);
      chk("bus", {m_chipselect, m_write_n, m_address, m_writedata},
          {b.cs, b.wn, b.addr, (b.kind == K_CLRW) ? {28'd0, m_last_cap} : b.wd});
      chk("busy", busy, have);
      chk("upd", upd, (b.kind == K_UPD));
      chk("pos0", pos0, m_pos0);
      chk("pos1", pos1, m_pos1);
      chk("err", {err1, err0}, {m_err1, m_err0});
      chk("last_cap", last_cap, m_last_cap);
      if (reset_n) begin
        if (have) begin
          void'(mq.pop_front());
          case (b.kind)
            K_PRIME: m_prev = m_readdata[3:0];
            K_CAP:   m_last_cap = m_readdata[3:0];
            K_CUR:   m_cur = m_readdata[3:0];
            K_UPD: begin
              step_of(m_prev[1:0], m_cur[1:0], d, e);
              m_pos0 = m_pos0 + TB_W'(d);
              if (e) m_err0 = 1;
              step_of(m_prev[3:2], m_cur[3:2], d, e);
              m_pos1 = m_pos1 + TB_W'(d);
              if (e) m_err1 = 1;
              m_prev = m_cur;
              m_idle_cnt = 0;
            end
            default: ;
          endcase
        end else if (en && irq_in) begin
          mq.push_back(mk(1, 1, 2'd3, 0, K_NONE));
          mq.push_back(mk(1, 1, 2'd3, 0, K_CAP));
          mq.push_back(mk(1, 0, 2'd3, 0, K_CLRW));
          push_dat();
        end else if (en && m_idle_cnt == TB_P - 1) begin
          push_dat();
        end else if (en) begin
          m_idle_cnt++;
        end
        if (clr) begin
          m_pos0 = '0; m_pos1 = '0; m_err0 = 0; m_err1 = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic wait_upd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!upd && n < 200);
    chk("wait_upd", upd, 1'b1);
  endtask

  initial begin : stim
    int cnt;
    reset_n = 1'b0;
    pins = '0;
    en = 1'b0;
    clr = 1'b0;
    tick(3);
    reset_n = 1'b1;

    // boot sequence, cycles 0..4
    @(negedge clk); chk("boot_c0_busy", busy, 1'b1);
    chk("boot_c0_bus", {m_chipselect, m_write_n, m_address, m_writedata}, {1'b0, 1'b1, 2'd0, 32'd0});
    @(negedge clk);
    chk("boot_c1_init", {m_chipselect, m_write_n, m_address, m_writedata}, {1'b1, 1'b0, 2'd2, 32'hF});
    @(negedge clk);
    chk("boot_c2_prime", {m_chipselect, m_write_n, m_address}, {1'b1, 1'b1, 2'd0});
    @(negedge clk);
    chk("boot_c3_prime", {m_chipselect, m_write_n, m_address}, {1'b1, 1'b1, 2'd0});
    @(negedge clk);
    chk("boot_c4_idle", {busy, pos0, pos1}, {1'b0, 8'd0, 8'd0});
    tick(1);
    en = 1'b1;

    // encoder 0 forward four steps then reverse four steps
    for (int i = 0; i < 4; i++) begin
      pins[1:0] = fwd(pins[1:0]);
      tick(GAP);
    end
    @(negedge clk); chk("fwd4_pos0", {err0, pos0}, {1'b0, 8'd4});
    for (int i = 0; i < 4; i++) begin
      case (pins[1:0])
        2'b00: pins[1:0] = 2'b10;
        2'b10: pins[1:0] = 2'b11;
        2'b11: pins[1:0] = 2'b01;
        default: pins[1:0] = 2'b00;
      endcase
      tick(GAP);
    end
    @(negedge clk); chk("rev4_pos0", pos0, 8'd0);

    // encoder 1 double step
    pins[3:2] = 2'b11;
    tick(GAP);
    @(negedge clk); chk("jump_err1", {err1, pos1}, {1'b1, 8'd0});
    tick(100);
    @(negedge clk); chk("jump_err1_sticky", err1, 1'b1);
    tick(1);
    pulse_clr();
    @(negedge clk); chk("clr_err1", err1, 1'b0);
    pins[3:2] = 2'b00;
    tick(GAP);
    pulse_clr();

    // randomized phase
    for (int i = 0; i < 150; i++) begin
      int enc;
      int act;
      enc = int'($urandom_range(1, 0));
      act = int'($urandom_range(99, 0));
      if (act < 40) begin
        if (enc == 0) pins[1:0] = fwd(pins[1:0]);
        else          pins[3:2] = fwd(pins[3:2]);
      end else if (act < 75) begin
        if (enc == 0) pins[1:0] = fwd(fwd(fwd(pins[1:0])));
        else          pins[3:2] = fwd(fwd(fwd(pins[3:2])));
      end else if (act < 83) begin
        if (enc == 0) pins[1:0] = fwd(fwd(pins[1:0]));
        else          pins[3:2] = fwd(fwd(pins[3:2]));
      end else if (act < 91) begin
        en = ~en;
      end else begin
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
      end
      tick(int'($urandom_range(50, 1)));
    end

    // quiesce to a known state
    en = 1'b1;
    pins = '0;
    tick(2 * GAP);
    pulse_clr();
    tick(GAP);

    // irq and poll expiry in the same cycle
    wait_upd();
    repeat (TB_P - 1) @(posedge clk);
    #1 pins[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("coinc_idle_irq", {busy, irq_in}, {1'b0, 1'b1});
    @(negedge clk); chk("coinc_cap_path", {m_chipselect, m_write_n, m_address}, {1'b1, 1'b1, 2'd3});
    cnt = 0;
    for (int i = 0; i < TB_P + 8; i++) begin
      if (upd) cnt++;
      @(negedge clk);
    end
    chk("coinc_one_upd", cnt, 1);
    tick(GAP);

    // en dropped mid-sequence
    wait_upd();
    tick(2);
    pins[1] = 1'b1;
    tick(3);
    en = 1'b0;
    tick(20);
    pins[2] = 1'b1;
    tick(30);
    @(negedge clk); chk("en0_hold", {busy, irq_in}, {1'b0, 1'b1});
    @(posedge clk);
    #1 en = 1'b1;
    @(negedge clk); chk("en1_same_cycle", busy, 1'b0);
    @(negedge clk); chk("en1_start", {busy, m_address}, {1'b1, 2'd3});
    tick(GAP);

    // wrap: 127 forward steps to 0x7F, one more to 0x80; enc1 reverse from 0
    pins = 4'b0000;
    tick(GAP);
    pulse_clr();
    tick(2);
    for (int i = 0; i < 127; i++) begin
      pins[1:0] = fwd(pins[1:0]);
      tick(GAP);
    end
    @(negedge clk); chk("wrap_pre", pos0, 8'h7F);
    pins[1:0] = fwd(pins[1:0]);
    tick(GAP);
    @(negedge clk); chk("wrap_pos0", pos0, 8'h80);
    pins[3:2] = 2'b10;
    tick(GAP);
    @(negedge clk); chk("wrap_pos1", pos1, 8'hFF);

    // reset mid-sequence
    tick(1);
    pins[3] = 1'b1;
    tick(3);
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", {busy, m_chipselect, m_write_n, pos0, pos1, err1, err0, last_cap},
        {1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 4'd0});
    tick(2);
    reset_n = 1'b1;
    tick(3 * GAP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
